// File: rtl/i2s_pkg.sv
// Shared types and default sizing for the I2S transmit scheduler.
package i2s_pkg;

  localparam int unsigned DEF_DATA_W = 24;
  localparam int unsigned DEF_SLOT_W = 32;
  localparam int unsigned DEF_DIV_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // SCK periods in one stereo frame.
  function automatic int unsigned frame_len(input int unsigned slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_sck_div.sv
// SCK generator: toggles sck every div+1 clk cycles while run is high.
// rise_c/fall_c flag the cycle whose closing edge registers the sck transition.
module i2s_sck_div
  import i2s_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             rise_c,
  output logic             fall_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             tc_c;

  assign tc_c   = run && (cnt_q == div);
  assign rise_c = tc_c && !sck_q;
  assign fall_c = tc_c && sck_q;
  assign sck    = sck_q;

  // Half-period counter; parked at zero with sck low when not running.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!run) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tc_c) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/i2s_tx_sched.sv
// I2S transmit frame scheduler: frame FSM, slot counter, MSB-first shifter
// with one-bit data delay, sample handshake and sticky underrun flag.
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SLOT_W = DEF_SLOT_W,
  parameter int unsigned DIV_W  = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              s_ready,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int unsigned FRAME_W = frame_len(SLOT_W);
  localparam int unsigned SLOT_CW = $clog2(FRAME_W);
  localparam int unsigned PAD_W   = SLOT_W - DATA_W;
  localparam logic [SLOT_CW-1:0] LAST_SLOT  = SLOT_CW'(FRAME_W - 1);
  localparam logic [SLOT_CW-1:0] RIGHT_SLOT = SLOT_CW'(SLOT_W);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SLOT_CW-1:0] slot_q, slot_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic               ws_q, ws_d;
  logic               sd_q, sd_d;
  logic               s_ready_q, s_ready_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;

  logic               run_c;
  logic               sck_rise_c;
  logic               sck_fall_c;
  logic [SLOT_CW-1:0] slot_inc_c;
  logic [FRAME_W-1:0] frame_word_c;

  assign run_c      = (state_q != IDLE);
  assign slot_inc_c = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_CW'(1);

  // Left-justified stereo frame: {left, pad, right, pad}.
  assign frame_word_c = {SLOT_W'(s_left) << PAD_W, SLOT_W'(s_right) << PAD_W};

  i2s_sck_div #(
    .DIV_W (DIV_W)
  ) u_sck_div (
    .clk    (clk),
    .reset  (reset),
    .run    (run_c),
    .div    (div_q),
    .sck    (sck),
    .rise_c (sck_rise_c),
    .fall_c (sck_fall_c)
  );

  // Next-state: frame sequencing on fall events, load in the s_ready cycle.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    slot_d       = slot_q;
    sh_d         = sh_q;
    ws_d         = ws_q;
    sd_d         = sd_q;
    s_ready_d    = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    underrun_d   = underrun_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = RUN;
          div_d     = clk_div;
          slot_d    = '0;
          ws_d      = 1'b0;
          sd_d      = 1'b0;
          s_ready_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        if (sck_fall_c) begin
          slot_d = slot_inc_c;
          ws_d   = (slot_inc_c >= RIGHT_SLOT);
          sd_d   = sh_q[FRAME_W-1];
          sh_d   = sh_q << 1;
          if (slot_q == LAST_SLOT) begin
            frame_done_d = 1'b1;
            if (enable) begin
              s_ready_d = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (sck_fall_c) begin
          state_d = IDLE;
          slot_d  = '0;
          ws_d    = 1'b0;
          sd_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // The strobe cycle is the load slot; an empty source yields a silent frame.
    if (s_ready_q) begin
      sh_d = s_valid ? frame_word_c : '0;
    end

    // Set has priority over clear.
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (s_ready_q && !s_valid) begin
      underrun_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      slot_q       <= '0;
      sh_q         <= '0;
      ws_q         <= 1'b0;
      sd_q         <= 1'b0;
      s_ready_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      slot_q       <= slot_d;
      sh_q         <= sh_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      s_ready_q    <= s_ready_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  // SCK may only rise while a frame or drain slot is in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(sck_rise_c && (state_q == IDLE)));
    end
  end

  assign s_ready    = s_ready_q;
  assign ws         = ws_q;
  assign sd         = sd_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Self-checking bench for i2s_tx_sched: decodes the serial stream on SCK rises.
module tb_i2s_tx_sched;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned DIV_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [DIV_W-1:0]  clk_div;
  logic              s_valid;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              s_ready;
  logic              sck;
  logic              ws;
  logic              sd;
  logic              busy;
  logic              frame_done;
  logic              underrun;
  logic              underrun_clr;

  i2s_tx_sched dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clk_div      (clk_div),
    .s_valid      (s_valid),
    .s_left       (s_left),
    .s_right      (s_right),
    .s_ready      (s_ready),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .busy         (busy),
    .frame_done   (frame_done),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Monitor: receiver-side view sampled on the falling clk edge.
  int   cyc = 0;
  logic prev_sck = 1'b0;
  logic prev_busy = 1'b0;
  logic rx_sd[$];
  logic rx_ws[$];
  int   rise_cyc[$];
  int   ready_cyc[$];
  int   fd_cnt = 0;
  int   entry_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sck && !prev_sck) begin
      rx_sd.push_back(sd);
      rx_ws.push_back(ws);
      rise_cyc.push_back(cyc);
    end
    if (s_ready) ready_cyc.push_back(cyc);
    if (frame_done) fd_cnt++;
    if (busy && !prev_busy) entry_cyc = cyc;
    prev_sck  = sck;
    prev_busy = busy;
  end

  typedef struct {
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    int                period;
    logic [DATA_W-1:0] exp_left;
    logic [DATA_W-1:0] exp_right;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    rx_sd.delete();
    rx_ws.delete();
    rise_cyc.delete();
    ready_cyc.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    enable       = 1'b0;
    underrun_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy) return;
    end
    timeout(name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (!busy) return;
    end
    timeout(name);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (s_ready) return;
    end
    timeout(name);
  endtask

  task automatic wait_rises(input int n, input string name);
    for (int i = 0; i < 6000; i++) begin
      if (rx_sd.size() >= n) return;
      tick();
    end
    timeout(name);
  endtask

  function automatic logic [63:0] bits(input int start, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], rx_sd[start+i]};
    return v;
  endfunction

  // One enabled-for-a-single-frame run, checked against a table record.
  task automatic run_vec(input int idx, input bit do_rst);
    string p;
    p = $sformatf("v%0d", idx);
    if (do_rst) do_reset();
    clk_div      = vecs[idx].div;
    s_left       = vecs[idx].left;
    s_right      = vecs[idx].right;
    s_valid      = 1'b1;
    underrun_clr = 1'b0;
    clear_mon();
    enable = 1'b1;
    wait_busy({p, "_busy"});
    enable = 1'b0;
    wait_idle({p, "_idle"});
    check({p, "_ready_cnt"}, 64'(ready_cyc.size()), 64'd1);
    check({p, "_ready_at_entry"}, 64'(ready_cyc[0]), 64'(entry_cyc));
    check({p, "_rises"}, 64'(rx_sd.size()), 64'd65);
    check({p, "_latency"}, 64'(rise_cyc[0] - entry_cyc), 64'(int'(vecs[idx].div) + 1));
    check({p, "_period"}, 64'(rise_cyc[1] - rise_cyc[0]), 64'(vecs[idx].period));
    check({p, "_slot0"}, 64'(rx_sd[0]), 64'd0);
    check({p, "_left"}, bits(1, 24), 64'(vecs[idx].exp_left));
    check({p, "_lpad"}, bits(25, 8), 64'd0);
    check({p, "_right"}, bits(33, 24), 64'(vecs[idx].exp_right));
    check({p, "_rpad"}, bits(57, 8), 64'd0);
    check({p, "_ws"}, 64'({rx_ws[0], rx_ws[31], rx_ws[32], rx_ws[63], rx_ws[64]}), 64'b00110);
    check({p, "_fdone"}, 64'(fd_cnt), 64'd1);
    check({p, "_end"}, 64'({sck, sd, ws, underrun}), 64'd0);
  endtask

  logic [DATA_W-1:0] lv[4];
  logic [DATA_W-1:0] rv[4];

  initial begin
    vecs[0] = '{div: 16'd1, left: 24'hABCDEF, right: 24'h123456, period: 4,
                exp_left: 24'hABCDEF, exp_right: 24'h123456};
    vecs[1] = '{div: 16'd0, left: 24'h800001, right: 24'h7FFFFE, period: 2,
                exp_left: 24'h800001, exp_right: 24'h7FFFFE};
    vecs[2] = '{div: 16'd2, left: 24'hFFFFFF, right: 24'h000000, period: 6,
                exp_left: 24'hFFFFFF, exp_right: 24'h000000};
    vecs[3] = '{div: 16'd0, left: 24'h000001, right: 24'h800000, period: 2,
                exp_left: 24'h000001, exp_right: 24'h800000};
    lv = '{24'h111111, 24'hA5A5A5, 24'h800000, 24'h00FF00};
    rv = '{24'h222222, 24'h5A5A5A, 24'h000001, 24'hFF00FF};

    // Reset with random inputs: all outputs low every cycle.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable       = 1'($urandom);
      clk_div      = 16'($urandom_range(0, 3));
      s_valid      = 1'($urandom);
      s_left       = 24'($urandom);
      s_right      = 24'($urandom);
      underrun_clr = 1'($urandom);
      tick();
      check($sformatf("reset_c%0d", i),
            64'({sck, ws, sd, s_ready, busy, frame_done, underrun}), 64'd0);
    end
    reset = 1'b0;
    enable = 1'b0;
    underrun_clr = 1'b0;

    // Reset mid-frame, then a clean restart.
    clk_div = 16'd1;
    s_valid = 1'b1;
    s_left  = 24'h0F0F0F;
    s_right = 24'hF0F0F0;
    clear_mon();
    enable = 1'b1;
    wait_rises(40, "mid_rises");
    reset = 1'b1;
    tick();
    check("mid_reset", 64'({sck, ws, sd, s_ready, busy, frame_done, underrun}), 64'd0);
    reset  = 1'b0;
    enable = 1'b0;
    run_vec(0, 1'b0);

    for (int v = 1; v < 4; v++) run_vec(v, 1'b1);

    // Underrun, clear, set-beats-clear, then stop mid frame 3.
    do_reset();
    clk_div = 16'd1;
    s_left  = 24'hABCDEF;
    s_right = 24'h123456;
    s_valid = 1'b1;
    clear_mon();
    enable = 1'b1;
    wait_ready("b_ready1");
    tick();
    s_valid = 1'b0;
    check("b_no_urun", 64'(underrun), 64'd0);
    wait_ready("b_ready2");
    tick();
    check("urun_set", 64'(underrun), 64'd1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("urun_clr", 64'(underrun), 64'd0);
    wait_ready("b_ready3");
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("urun_set_wins", 64'(underrun), 64'd1);
    wait_rises(139, "b_slot10");
    enable = 1'b0;
    wait_idle("b_idle");
    check("b_fdone", 64'(fd_cnt), 64'd3);
    check("b_ready_cnt", 64'(ready_cyc.size()), 64'd3);
    check("b_rises", 64'(rx_sd.size()), 64'd193);
    check("b_f1_left", bits(1, 24), 64'h0ABCDEF);
    check("b_f1_right", bits(33, 24), 64'h0123456);
    check("b_f2_zero", bits(65, 64), 64'd0);
    check("b_f3_zero", bits(129, 64), 64'd0);
    check("b_drain_ws", 64'({rx_ws[191], rx_ws[192]}), 64'b10);
    check("b_end", 64'({busy, sck, sd}), 64'd0);

    // Four back-to-back frames at the fastest SCK.
    do_reset();
    clk_div = 16'd0;
    s_valid = 1'b1;
    s_left  = lv[0];
    s_right = rv[0];
    clear_mon();
    enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_ready($sformatf("c_ready%0d", f));
      tick();
      if (f < 3) begin
        s_left  = lv[f+1];
        s_right = rv[f+1];
      end else begin
        enable = 1'b0;
      end
    end
    wait_idle("c_idle");
    check("c_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'd2);
    for (int f = 1; f < 4; f++)
      check($sformatf("c_ready_gap%0d", f), 64'(ready_cyc[f] - ready_cyc[f-1]), 64'd128);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("c_left%0d", f), bits(f*64 + 1, 24), 64'(lv[f]));
      check($sformatf("c_right%0d", f), bits(f*64 + 33, 24), 64'(rv[f]));
    end
    check("c_urun", 64'(underrun), 64'd0);
    check("c_fdone", 64'(fd_cnt), 64'd4);
    check("c_rises", 64'(rx_sd.size()), 64'd257);

    // Divider changes only take effect after passing through IDLE.
    do_reset();
    clk_div = 16'd1;
    s_valid = 1'b1;
    clear_mon();
    enable = 1'b1;
    wait_rises(5, "d_rises5");
    clk_div = 16'd3;
    wait_rises(20, "d_rises20");
    check("d_period_held", 64'(rise_cyc[19] - rise_cyc[18]), 64'd4);
    enable = 1'b0;
    wait_idle("d_idle1");
    clear_mon();
    enable = 1'b1;
    wait_busy("d_busy2");
    enable = 1'b0;
    wait_rises(3, "d_rises3");
    check("d_latency_new", 64'(rise_cyc[0] - entry_cyc), 64'd4);
    check("d_period_new", 64'(rise_cyc[2] - rise_cyc[1]), 64'd8);
    wait_idle("d_idle2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
